// File: rtl/game_state_nxn_if.sv
// Move handshake between the keypad decoder (master) and the game-state
// engine (slave): request with target cell, ready, and one-cycle ack/err pulses.
interface game_state_nxn_if #(
  parameter int IW = 4
) ();
  logic          move_valid;
  logic [IW-1:0] move_idx;
  logic          move_ready;
  logic          move_ack;
  logic          move_err;

  modport master (
    output move_valid,
    output move_idx,
    input  move_ready,
    input  move_ack,
    input  move_err
  );

  modport slave (
    input  move_valid,
    input  move_idx,
    output move_ready,
    output move_ack,
    output move_err
  );
endinterface

// File: rtl/game_state_nxn.sv
// N x N, K-in-a-row game-state engine: accepts and validates moves, alternates
// turns, and scans the four lines through the last move over four cycles.
module game_state_nxn #(
  parameter int N       = 3,
  parameter int K       = 3,
  parameter bit FIRST_O = 1'b0,
  parameter int IW      = $clog2(N*N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  game_state_nxn_if.slave  mv,
  output logic [2*N*N-1:0] board,
  output logic             turn_o,
  output logic [6:0]       move_count,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic             is_draw
);
  localparam int CELLS = N * N;
  localparam int BW    = $clog2(2 * CELLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  logic [2*CELLS-1:0] board_r;
  logic               turn_r;
  logic [6:0]         count_r;
  logic               game_over_r;
  logic [1:0]         winner_r;
  logic               is_draw_r;
  logic               ready_r;
  logic               ack_r;
  logic               err_r;
  logic [3:0]         last_row_r;
  logic [3:0]         last_col_r;
  logic [1:0]         dir_r;
  logic               win_r;

  logic [IW-1:0]      idx_s;
  int                 mv_row_s;
  int                 mv_col_s;
  logic               legal_s;
  logic [BW-1:0]      wr_bi_s;
  logic [1:0]         mark_s;
  int                 dr_s;
  int                 dc_s;
  int                 r0_s;
  int                 c0_s;
  logic               go_p_s;
  logic               go_n_s;
  logic [4:0]         run_s;
  logic               run_hit_s;

  // Off-board coordinates read as empty, so line stepping halts at the edge.
  function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int r, input int c);
    logic [BW-1:0] bi;
    logic [1:0]    v;
    if ((r >= 32'sd0) && (r < N) && (c >= 32'sd0) && (c < N)) begin
      bi = BW'((r * N + c) * 32'sd2);
      v  = b[bi +: 2];
    end else begin
      bi = {BW{1'b0}};
      v  = 2'b00;
    end
    return v;
  endfunction

  // Decode the requested cell and its legality against the current board.
  always_comb begin
    idx_s    = mv.move_idx;
    mv_row_s = int'(idx_s) / N;
    mv_col_s = int'(idx_s) % N;
    legal_s  = (int'(idx_s) < CELLS) && (cell_at(board_r, mv_row_s, mv_col_s) == 2'b00);
    wr_bi_s  = BW'({idx_s, 1'b0});
    mark_s   = turn_r ? 2'b10 : 2'b01;
  end

  // Run length through the last move along the direction selected by dir_r.
  always_comb begin
    r0_s   = int'(last_row_r);
    c0_s   = int'(last_col_r);
    go_p_s = 1'b1;
    go_n_s = 1'b1;
    run_s  = 5'd1;
    case (dir_r)
      2'd0:    begin dr_s = 32'sd0; dc_s = 32'sd1;  end
      2'd1:    begin dr_s = 32'sd1; dc_s = 32'sd0;  end
      2'd2:    begin dr_s = 32'sd1; dc_s = 32'sd1;  end
      2'd3:    begin dr_s = 32'sd1; dc_s = -32'sd1; end
      default: begin dr_s = 32'sd0; dc_s = 32'sd0;  end
    endcase
    for (int s = 32'sd1; s < K; s = s + 32'sd1) begin
      if (go_p_s && (cell_at(board_r, r0_s + s * dr_s, c0_s + s * dc_s) == mark_s)) begin
        run_s = run_s + 5'd1;
      end else begin
        go_p_s = 1'b0;
      end
      if (go_n_s && (cell_at(board_r, r0_s - s * dr_s, c0_s - s * dc_s) == mark_s)) begin
        run_s = run_s + 5'd1;
      end else begin
        go_n_s = 1'b0;
      end
    end
    run_hit_s = (run_s >= 5'(K));
  end

  // Game FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      board_r     <= {(2*CELLS){1'b0}};
      turn_r      <= FIRST_O;
      count_r     <= 7'd0;
      game_over_r <= 1'b0;
      winner_r    <= 2'b00;
      is_draw_r   <= 1'b0;
      ready_r     <= 1'b0;
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
      last_row_r  <= 4'd0;
      last_col_r  <= 4'd0;
      dir_r       <= 2'd0;
      win_r       <= 1'b0;
    end else if (start) begin
      state_r     <= PLAY;
      board_r     <= {(2*CELLS){1'b0}};
      turn_r      <= FIRST_O;
      count_r     <= 7'd0;
      game_over_r <= 1'b0;
      winner_r    <= 2'b00;
      is_draw_r   <= 1'b0;
      ready_r     <= 1'b1;
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
      dir_r       <= 2'd0;
      win_r       <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        IDLE: ready_r <= 1'b0;
        PLAY: begin
          if (mv.move_valid && ready_r) begin
            if (legal_s) begin
              board_r[wr_bi_s +: 2] <= mark_s;
              count_r    <= count_r + 7'd1;
              ack_r      <= 1'b1;
              last_row_r <= 4'(mv_row_s);
              last_col_r <= 4'(mv_col_s);
              dir_r      <= 2'd0;
              win_r      <= 1'b0;
              ready_r    <= 1'b0;
              state_r    <= CHECK;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        CHECK: begin
          win_r <= win_r | run_hit_s;
          dir_r <= dir_r + 2'd1;
          // Win is tested before the full-board draw so a last-cell win is reported.
          if (dir_r == 2'd3) begin
            if (win_r || run_hit_s) begin
              state_r     <= DONE;
              winner_r    <= mark_s;
              game_over_r <= 1'b1;
            end else if (count_r == 7'(CELLS)) begin
              state_r     <= DONE;
              is_draw_r   <= 1'b1;
              game_over_r <= 1'b1;
            end else begin
              state_r <= PLAY;
              turn_r  <= ~turn_r;
              ready_r <= 1'b1;
            end
          end
        end
        DONE: ready_r <= 1'b0;
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign mv.move_ready = ready_r;
  assign mv.move_ack   = ack_r;
  assign mv.move_err   = err_r;
  assign board         = board_r;
  assign turn_o        = turn_r;
  assign move_count    = count_r;
  assign game_over     = game_over_r;
  assign winner        = winner_r;
  assign is_draw       = is_draw_r;
endmodule

// File: tb/tb_game_state_nxn.sv
// Directed bench for game_state_nxn: a 3x3/K=3 core, a 5x5/K=4 core and a
// 3x3 core with O moving first, each driven through its own handshake interface.
module tb_game_state_nxn;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1, start2;
  logic       valid0, valid1, valid2;
  logic [3:0] idx0;
  logic [4:0] idx1;
  logic [3:0] idx2;

  logic [17:0] board0, board2;
  logic [49:0] board1;
  logic        turn0, turn1, turn2;
  logic [6:0]  cnt0, cnt1, cnt2;
  logic        go0, go1, go2;
  logic [1:0]  win0, win1, win2;
  logic        draw0, draw1, draw2;

  game_state_nxn_if #(.IW(4)) if0 ();
  game_state_nxn_if #(.IW(5)) if1 ();
  game_state_nxn_if #(.IW(4)) if2 ();

  assign if0.move_valid = valid0;
  assign if0.move_idx   = idx0;
  assign if1.move_valid = valid1;
  assign if1.move_idx   = idx1;
  assign if2.move_valid = valid2;
  assign if2.move_idx   = idx2;

  game_state_nxn #(.N(3), .K(3), .FIRST_O(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .mv(if0.slave), .board(board0), .turn_o(turn0),
    .move_count(cnt0), .game_over(go0), .winner(win0), .is_draw(draw0));
  game_state_nxn #(.N(5), .K(4), .FIRST_O(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .mv(if1.slave), .board(board1), .turn_o(turn1),
    .move_count(cnt1), .game_over(go1), .winner(win1), .is_draw(draw1));
  game_state_nxn #(.N(3), .K(3), .FIRST_O(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .mv(if2.slave), .board(board2), .turn_o(turn2),
    .move_count(cnt2), .game_over(go2), .winner(win2), .is_draw(draw2));

  int          cur;
  logic [63:0] ob_board;
  logic        ob_turn, ob_go, ob_draw, ob_ready, ob_ack, ob_err;
  logic [6:0]  ob_cnt;
  logic [1:0]  ob_win;

  always_comb begin
    case (cur)
      1: begin
        ob_board = 64'(board1); ob_turn = turn1; ob_go = go1; ob_draw = draw1;
        ob_ready = if1.move_ready; ob_ack = if1.move_ack; ob_err = if1.move_err;
        ob_cnt = cnt1; ob_win = win1;
      end
      2: begin
        ob_board = 64'(board2); ob_turn = turn2; ob_go = go2; ob_draw = draw2;
        ob_ready = if2.move_ready; ob_ack = if2.move_ack; ob_err = if2.move_err;
        ob_cnt = cnt2; ob_win = win2;
      end
      default: begin
        ob_board = 64'(board0); ob_turn = turn0; ob_go = go0; ob_draw = draw0;
        ob_ready = if0.move_ready; ob_ack = if0.move_ack; ob_err = if0.move_err;
        ob_cnt = cnt0; ob_win = win0;
      end
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;
  int seq[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_cur(input int n);
    cur = n;
    #1;
  endtask

  task automatic drive(input logic st, input logic v, input int idx);
    case (cur)
      1:       begin start1 = st; valid1 = v; idx1 = 5'(idx); end
      2:       begin start2 = st; valid2 = v; idx2 = 4'(idx); end
      default: begin start0 = st; valid0 = v; idx0 = 4'(idx); end
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input logic exp_turn);
    check_eq("rst_board", ob_board, 64'd0);
    check_eq("rst_count", 64'(ob_cnt), 64'd0);
    check_eq("rst_winner", 64'(ob_win), 64'd0);
    check_eq("rst_flags", {ob_go, ob_draw, ob_ready, ob_ack, ob_err}, 5'b00000);
    check_eq("rst_turn", 64'(ob_turn), 64'(exp_turn));
  endtask

  task automatic new_game();
    drive(1'b1, 1'b0, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0);
    check_eq("start_ready", 64'(ob_ready), 64'd1);
  endtask

  task automatic move(input int idx, input logic legal);
    int w;
    w = 0;
    while (!ob_ready && (w < 20)) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_move", 64'(ob_ready), 64'd1);
    drive(1'b0, 1'b1, idx);
    @(negedge clk);
    drive(1'b0, 1'b0, 0);
    check_eq("ack", 64'(ob_ack), 64'(legal));
    check_eq("err", 64'(ob_err), 64'(!legal));
  endtask

  task automatic play_seq();
    foreach (seq[i]) move(seq[i], 1'b1);
  endtask

  task automatic hold_valid(input int n, input int idx);
    drive(1'b0, 1'b1, idx);
    repeat (n) begin
      @(negedge clk);
      check_eq("ignored_valid", {ob_ack, ob_err, ob_ready}, 3'b000);
    end
    drive(1'b0, 1'b0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = 0;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    idx0 = 4'd0; idx1 = 5'd0; idx2 = 4'd0;
    cycles(3);
    rst = 1'b0;
    set_cur(0); check_reset(1'b0);
    set_cur(1); check_reset(1'b0);
    set_cur(2); check_reset(1'b1);

    // 3x3: IDLE ignores moves, then a row win for X
    set_cur(0);
    hold_valid(3, 0);
    check_eq("idle_board", ob_board, 64'd0);
    new_game();
    seq = '{0, 3, 1, 4, 2};
    play_seq();
    cycles(3);
    check_eq("row_latency", 64'(ob_go), 64'd0);
    cycles(1);
    check_eq("row_over", 64'(ob_go), 64'd1);
    check_eq("row_winner", 64'(ob_win), 64'd1);
    check_eq("row_board", ob_board, 64'h295);
    check_eq("row_count", 64'(ob_cnt), 64'd5);
    check_eq("row_turn", 64'(ob_turn), 64'd0);
    check_eq("row_draw", 64'(ob_draw), 64'd0);
    hold_valid(3, 5);
    check_eq("done_board", ob_board, 64'h295);

    // start in DONE with a simultaneous move request
    drive(1'b1, 1'b1, 5);
    @(negedge clk);
    drive(1'b0, 1'b0, 0);
    check_eq("restart_board", ob_board, 64'd0);
    check_eq("restart_pulses", {ob_ack, ob_err}, 2'b00);
    check_eq("restart_state", {ob_ready, ob_go, ob_turn}, 3'b100);
    check_eq("restart_winner", 64'(ob_win), 64'd0);
    check_eq("restart_count", 64'(ob_cnt), 64'd0);

    // illegal moves: occupied cell, then out of range
    move(4, 1'b1);
    move(4, 1'b0);
    check_eq("occ_board", ob_board, 64'h100);
    check_eq("occ_count", 64'(ob_cnt), 64'd1);
    check_eq("occ_turn", 64'(ob_turn), 64'd1);
    check_eq("occ_ready", 64'(ob_ready), 64'd1);
    move(9, 1'b0);
    check_eq("oob_board", ob_board, 64'h100);
    check_eq("oob_count", 64'(ob_cnt), 64'd1);

    // full board with no line
    new_game();
    seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    play_seq();
    cycles(4);
    check_eq("draw_over", 64'(ob_go), 64'd1);
    check_eq("draw_flag", 64'(ob_draw), 64'd1);
    check_eq("draw_winner", 64'(ob_win), 64'd0);
    check_eq("draw_count", 64'(ob_cnt), 64'd9);

    // start during CHECK discards the scan
    new_game();
    move(0, 1'b1);
    drive(1'b1, 1'b0, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0);
    check_eq("midchk_board", ob_board, 64'd0);
    check_eq("midchk_count", 64'(ob_cnt), 64'd0);
    cycles(5);
    check_eq("midchk_state", {ob_ready, ob_go, ob_turn}, 3'b100);
    check_eq("midchk_board2", ob_board, 64'd0);

    // rst in the second CHECK cycle
    new_game();
    move(0, 1'b1);
    cycles(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset(1'b0);
    cycles(2);
    check_eq("idle_after_rst", 64'(ob_ready), 64'd0);

    // 5x5, K=4: anti-diagonal win ending on an edge cell
    set_cur(1);
    new_game();
    seq = '{4, 0, 8, 1, 12, 2, 16};
    play_seq();
    cycles(4);
    check_eq("anti_over", 64'(ob_go), 64'd1);
    check_eq("anti_winner", 64'(ob_win), 64'd1);
    check_eq("anti_count", 64'(ob_cnt), 64'd7);

    // X at 3,4 (row 0 end) and 5,6 (row 1 start): no wrap-around win
    new_game();
    seq = '{3, 10, 4, 11, 5, 20, 6};
    play_seq();
    cycles(4);
    check_eq("wrap_state", {ob_go, ob_ready, ob_turn}, 3'b011);
    check_eq("wrap_winner", 64'(ob_win), 64'd0);
    check_eq("wrap_count", 64'(ob_cnt), 64'd7);

    // O moves first
    set_cur(2);
    new_game();
    check_eq("o_first_turn", 64'(ob_turn), 64'd1);
    move(0, 1'b1);
    check_eq("o_first_cell", ob_board, 64'h2);
    seq = '{3, 1, 4, 2};
    play_seq();
    cycles(4);
    check_eq("o_win_over", 64'(ob_go), 64'd1);
    check_eq("o_win_winner", 64'(ob_win), 64'd2);
    check_eq("o_win_board", ob_board, 64'h16A);
    check_eq("o_win_turn", 64'(ob_turn), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/game_state_nxn.md
Name: game_state_nxn

Overview:
- Parametrised game-state engine for N x N, K-in-a-row games; generalises the fixed 3x3 tic-tac-toe board to configurable side and win length.
- Accepts one move per handshake, rejects illegal moves, and alternates turns.
- Detects win or draw with a fixed-latency sequential line scan.
- Sits between the keypad decoder and the display and dot-matrix blocks. Its outputs are registered board and status signals.

Parameters:
- N, 3, board side length; legal range 3..8.
- K, 3, marks in a line needed to win; 2 <= K <= N.
- FIRST_O, 0, player moving first after start: 0 = P1 (X), 1 = P2 (O).
- IW, $clog2(N*N), width of move_idx, derived; do not override.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse: clears the board and begins a new game.
- move_valid  in  1  move request.
- move_idx  in  IW  target cell, row*N+col.
- move_ready  out  1  high only in PLAY.
- move_ack  out  1  one-cycle pulse: move placed.
- move_err  out  1  one-cycle pulse: move rejected.
- board  out  2*N*N  cell i at bits [2i+1:2i]; 00 = empty, 01 = X (P1), 10 = O (P2).
- turn_o  out  1  0 = P1 to move, 1 = P2 to move; drives the P1/P2 display.
- move_count  out  7  number of marks placed.
- game_over  out  1  high in DONE.
- winner  out  2  00 = none/draw, 01 = P1, 10 = P2.
- is_draw  out  1  high when the game ended with no winner.

Behaviour:
- Reset and interface: clock and reset are one clock, named clk; reset is synchronous, active-high, named rst.
- Reset values:
  - state = IDLE.
  - board = 0, move_count = 0, winner = 00.
  - game_over = 0, is_draw = 0, move_ready = 0, move_ack = 0, move_err = 0.
  - turn_o = FIRST_O.
- Priority: rst > start > move handshake.
- start in any state, including mid-CHECK:
  - Next cycle: board = 0, move_count = 0, winner = 00, game_over = 0, is_draw = 0, turn_o = FIRST_O, state = PLAY.
  - Any scan in progress is discarded.
- States: IDLE, PLAY, CHECK, DONE.
- IDLE: move_ready = 0; move_valid is ignored; transitions to PLAY only on start.
- PLAY:
  - Handshake completes when move_valid && move_ready in cycle t.
  - Legal move (move_idx < N*N and the cell is 00):
    - At t+1: cell = 01 if turn_o = 0, else 10; move_count++; move_ack = 1; last-move row/col latched; state = CHECK.
  - Illegal move (move_idx >= N*N or cell occupied):
    - At t+1: move_err = 1; board, turn_o and move_count unchanged; state stays PLAY; move_ready stays 1.
- CHECK:
  - Exactly 4 cycles, one per direction in the order horizontal, vertical, diagonal (+1,+1), anti-diagonal (+1,-1).
  - Each cycle computes the run length through the last cell: 1 + contiguous same-mark cells stepping up to K-1 in each sense.
  - Stepping stops at the board edge; there is no wrap-around.
  - A run >= K sets the internal win flag.
  - move_ready = 0 throughout; move_valid is ignored.
- After the 4th CHECK cycle, i.e. the state update at t+5 (t = accept cycle):
  - Win: state = DONE; winner = 01/10 (the mover); game_over = 1; turn_o unchanged.
  - Else if move_count == N*N: state = DONE; is_draw = 1; game_over = 1; winner = 00.
  - Else: state = PLAY; turn_o toggles.
  - A win on the final cell reports the win, not a draw.
- DONE: all outputs hold; move_valid is ignored; start begins a new game.
- Pulse rules:
  - move_ack and move_err are never high together.
  - Each is high for exactly one cycle per handshake.
- Win reference: the first legal move can produce a win only when K <= 1, which is excluded by K >= 2.
- Board index mapping: row = idx / N, col = idx % N, computed without truncation for N up to 8 (idx up to 63).

Test Plan:
- Row win (N=3, K=3): start, then moves 0,3,1,4,2 (each waits for move_ready) -> 5 move_ack pulses; 5 cycles after the last accept, game_over = 1, winner = 01, board = 18'h00295, move_count = 5, turn_o = 0.
- Draw (N=3): moves 0,1,2,4,3,5,7,6,8 -> game_over = 1, is_draw = 1, winner = 00, move_count = 9.
- Illegal moves (N=3):
  - Move 4, then 4 -> one move_ack, then one move_err; board = 18'h00100, move_count = 1, turn_o = 1.
  - Move 9 -> move_err, no change.
  - move_valid held in IDLE and DONE -> no ack or err.
- Anti-diagonal, edge stop (N=5, K=4): moves 4,0,8,1,12,2,16 -> winner = 01 after the 7th move.
  - Separately, P1 at 3,4 plus P2 elsewhere, and P1 at 5 -> no horizontal win across the row boundary (no wrap).
- Reset and restart:
  - rst asserted in the 2nd CHECK cycle -> next cycle all outputs at reset values, state IDLE.
  - start during DONE -> PLAY with board = 0, turn_o = FIRST_O.
  - start with simultaneous move_valid -> move ignored.
- FIRST_O = 1: first legal move writes 10; the winner encoding follows the mover.
